// File: rtl/demux_pkg.sv
// Shared defaults and slot state encoding for the one-to-two demultiplexer.
package demux_pkg;

    localparam int DEMUX_WIDTH = 32;
    localparam int DEMUX_CNT_W = 8;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } slot_state_t;

    // An unknown or floating select steers to branch one.
    function automatic logic sel_is_two(input logic sel);
        return (sel === 1'b1);
    endfunction

endpackage : demux_pkg

// File: rtl/demux_one_to_two_if.sv
// Upstream/downstream handshake bundle; slave = demux side, master = environment side.
interface demux_one_to_two_if
    import demux_pkg::*;
#(
    parameter int WIDTH = DEMUX_WIDTH
);
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_select;
    logic             ou_ready;
    logic [WIDTH-1:0] ou_one_data;
    logic [WIDTH-1:0] ou_two_data;
    logic             ou_one_valid;
    logic             ou_two_valid;
    logic             in_one_ready;
    logic             in_two_ready;

    modport slave (
        input  in_data, in_valid, in_select, in_one_ready, in_two_ready,
        output ou_ready, ou_one_data, ou_two_data, ou_one_valid, ou_two_valid
    );

    modport master (
        output in_data, in_valid, in_select, in_one_ready, in_two_ready,
        input  ou_ready, ou_one_data, ou_two_data, ou_one_valid, ou_two_valid
    );
endinterface : demux_one_to_two_if

// File: rtl/demux_slot.sv
// One-entry register slot: fills from upstream, drains to downstream, refills on the draining cycle.
module demux_slot
    import demux_pkg::*;
#(
    parameter int WIDTH = DEMUX_WIDTH
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_fill,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_rdy,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data,
    output logic             o_can_take
);
    slot_state_t      r_state;
    slot_state_t      w_state_nxt;
    logic [WIDTH-1:0] r_data;
    logic             w_drain;
    logic             w_fill;

    assign w_drain    = (r_state == FULL) && i_rdy;
    assign o_can_take = (r_state == EMPTY) || w_drain;
    assign w_fill     = i_fill && o_can_take;
    assign o_valid    = (r_state == FULL);
    assign o_data     = r_data;

    // Slot occupancy register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Occupancy transitions: a fill wins over a drain so a simultaneous pair leaves no bubble.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            EMPTY: begin
                if (w_fill) w_state_nxt = FULL;
                else        w_state_nxt = EMPTY;
            end
            FULL: begin
                if (w_fill)       w_state_nxt = FULL;
                else if (w_drain) w_state_nxt = EMPTY;
                else              w_state_nxt = FULL;
            end
            default: w_state_nxt = EMPTY;
        endcase
    end

    // Payload register, held while the slot is not refilled.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_data <= {WIDTH{1'b0}};
        end else if (w_fill) begin
            r_data <= i_data;
        end else begin
            r_data <= r_data;
        end
    end
endmodule : demux_slot

// File: rtl/demux_one_to_two.sv
// One-to-two demultiplexer with a one-entry slot per branch.
// Optional per-branch accepted-beat counters are built when DEMUX_COUNT_EN is defined.
module demux_one_to_two
    import demux_pkg::*;
#(
    parameter int WIDTH = DEMUX_WIDTH,
    parameter int CNT_W = DEMUX_CNT_W
) (
    input  logic                    in_clk,
    input  logic                    in_rst,
    demux_one_to_two_if.slave       bus
`ifdef DEMUX_COUNT_EN
    ,
    output logic [CNT_W-1:0]        ou_one_count,
    output logic [CNT_W-1:0]        ou_two_count
`endif
);
    logic w_sel_two;
    logic w_one_can_take;
    logic w_two_can_take;
    logic w_acc_one;
    logic w_acc_two;

    assign w_sel_two    = sel_is_two(bus.in_select);
    assign bus.ou_ready = w_sel_two ? w_two_can_take : w_one_can_take;
    assign w_acc_one    = bus.in_valid && !w_sel_two && w_one_can_take;
    assign w_acc_two    = bus.in_valid &&  w_sel_two && w_two_can_take;

    demux_slot #(.WIDTH(WIDTH)) u_slot_one (
        .i_clk      (in_clk),
        .i_rst      (in_rst),
        .i_fill     (w_acc_one),
        .i_data     (bus.in_data),
        .i_rdy      (bus.in_one_ready),
        .o_valid    (bus.ou_one_valid),
        .o_data     (bus.ou_one_data),
        .o_can_take (w_one_can_take)
    );

    demux_slot #(.WIDTH(WIDTH)) u_slot_two (
        .i_clk      (in_clk),
        .i_rst      (in_rst),
        .i_fill     (w_acc_two),
        .i_data     (bus.in_data),
        .i_rdy      (bus.in_two_ready),
        .o_valid    (bus.ou_two_valid),
        .o_data     (bus.ou_two_data),
        .o_can_take (w_two_can_take)
    );

`ifdef DEMUX_COUNT_EN
    logic [CNT_W-1:0] r_one_count;
    logic [CNT_W-1:0] r_two_count;

    // Accepted-beat counters, wrapping modulo 2^CNT_W.
    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            r_one_count <= {CNT_W{1'b0}};
            r_two_count <= {CNT_W{1'b0}};
        end else begin
            if (w_acc_one) r_one_count <= r_one_count + CNT_W'(1);
            else           r_one_count <= r_one_count;
            if (w_acc_two) r_two_count <= r_two_count + CNT_W'(1);
            else           r_two_count <= r_two_count;
        end
    end

    assign ou_one_count = r_one_count;
    assign ou_two_count = r_two_count;
`endif
endmodule : demux_one_to_two

// File: tb/tb_demux_one_to_two.sv
// Directed plus randomized bench for demux_one_to_two against a queue-based branch model.
module tb_demux_one_to_two;
    import demux_pkg::*;

    localparam int W  = 32;
    localparam int CW = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    demux_one_to_two_if #(.WIDTH(W)) bus ();

`ifdef DEMUX_COUNT_EN
    logic [CW-1:0] one_cnt;
    logic [CW-1:0] two_cnt;
`endif

    demux_one_to_two #(.WIDTH(W), .CNT_W(CW)) dut (
        .in_clk       (clk),
        .in_rst       (rst),
        .bus          (bus.slave)
`ifdef DEMUX_COUNT_EN
        ,
        .ou_one_count (one_cnt),
        .ou_two_count (two_cnt)
`endif
    );

    // Reference model: each branch is a FIFO of capacity one, plus a beat counter.
    logic [W-1:0]  mq0[$];
    logic [W-1:0]  mq1[$];
    logic [CW-1:0] mcnt0;
    logic [CW-1:0] mcnt1;
    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_out();
        chk("one_valid", {63'd0, bus.ou_one_valid}, {63'd0, mq0.size() > 0});
        chk("two_valid", {63'd0, bus.ou_two_valid}, {63'd0, mq1.size() > 0});
        if (mq0.size() > 0) chk("one_data", {32'd0, bus.ou_one_data}, {32'd0, mq0[0]});
        if (mq1.size() > 0) chk("two_data", {32'd0, bus.ou_two_data}, {32'd0, mq1[0]});
`ifdef DEMUX_COUNT_EN
        chk("one_count", {56'd0, one_cnt}, {56'd0, mcnt0});
        chk("two_count", {56'd0, two_cnt}, {56'd0, mcnt1});
`endif
    endtask

    // Drive one cycle of inputs (called just after a falling edge), check ready, step the model across the rising edge.
    task automatic cyc(input logic [W-1:0] d, input logic v, input logic s, input logic r1, input logic r2);
        bit two;
        bit rdy_e;
        two = (s === 1'b1);
        bus.in_data      = d;
        bus.in_valid     = v;
        bus.in_select    = s;
        bus.in_one_ready = r1;
        bus.in_two_ready = r2;
        #1;
        rdy_e = two ? (mq1.size() == 0 || r2) : (mq0.size() == 0 || r1);
        chk("ready", {63'd0, bus.ou_ready}, {63'd0, rdy_e});
        if (mq0.size() > 0 && r1) void'(mq0.pop_front());
        if (mq1.size() > 0 && r2) void'(mq1.pop_front());
        if (v && rdy_e) begin
            if (two) begin mq1.push_back(d); mcnt1 = mcnt1 + 8'd1; end
            else     begin mq0.push_back(d); mcnt0 = mcnt0 + 8'd1; end
        end
        @(negedge clk);
        check_out();
    endtask

    // Assert reset away from any rising edge and check the cleared state before the next edge.
    task automatic apply_reset();
        rst = 1'b1;
        #1;
        mq0.delete();
        mq1.delete();
        mcnt0 = 8'd0;
        mcnt1 = 8'd0;
        chk("rst_one_valid", {63'd0, bus.ou_one_valid}, 64'd0);
        chk("rst_two_valid", {63'd0, bus.ou_two_valid}, 64'd0);
        chk("rst_one_data",  {32'd0, bus.ou_one_data},  64'd0);
        chk("rst_two_data",  {32'd0, bus.ou_two_data},  64'd0);
        chk("rst_ready",     {63'd0, bus.ou_ready},     64'd1);
`ifdef DEMUX_COUNT_EN
        chk("rst_one_count", {56'd0, one_cnt}, 64'd0);
        chk("rst_two_count", {56'd0, two_cnt}, 64'd0);
`endif
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        bus.in_data      = '0;
        bus.in_valid     = 1'b0;
        bus.in_select    = 1'b0;
        bus.in_one_ready = 1'b1;
        bus.in_two_ready = 1'b1;
        @(negedge clk);
        apply_reset();

        // Single beat to branch one.
        cyc(32'hA5A5A5A5, 1'b1, 1'b0, 1'b1, 1'b1);
        chk("b030_data", {32'd0, bus.ou_one_data}, 64'hA5A5A5A5);
        chk("b030_two_valid", {63'd0, bus.ou_two_valid}, 64'd0);
        cyc(32'h0, 1'b0, 1'b0, 1'b1, 1'b1);
        chk("b030_one_drop", {63'd0, bus.ou_one_valid}, 64'd0);

        // Branch two stalled: second beat waits until downstream frees the slot.
        cyc(32'h11, 1'b1, 1'b1, 1'b1, 1'b0);
        cyc(32'h22, 1'b1, 1'b1, 1'b1, 1'b0);
        chk("b031_held", {32'd0, bus.ou_two_data}, 64'h11);
        cyc(32'h22, 1'b1, 1'b1, 1'b1, 1'b0);
        cyc(32'h22, 1'b1, 1'b1, 1'b1, 1'b1);
        chk("b031_next", {32'd0, bus.ou_two_data}, 64'h22);
        cyc(32'h0, 1'b0, 1'b0, 1'b1, 1'b1);

        // Back-to-back beats stream with no stall.
        cyc(32'h1, 1'b1, 1'b0, 1'b1, 1'b1);
        chk("b032_d1", {32'd0, bus.ou_one_data}, 64'h1);
        cyc(32'h2, 1'b1, 1'b0, 1'b1, 1'b1);
        chk("b032_d2", {32'd0, bus.ou_one_data}, 64'h2);
        cyc(32'h3, 1'b1, 1'b0, 1'b1, 1'b1);
        chk("b032_d3", {32'd0, bus.ou_one_data}, 64'h3);
        cyc(32'h0, 1'b0, 1'b0, 1'b1, 1'b1);

        // Branch one full and stalled does not block branch two.
        cyc(32'h77, 1'b1, 1'b0, 1'b0, 1'b1);
        cyc(32'h55, 1'b1, 1'b1, 1'b0, 1'b1);
        chk("b033_two", {32'd0, bus.ou_two_data}, 64'h55);
        chk("b033_one", {32'd0, bus.ou_one_data}, 64'h77);
        cyc(32'h0, 1'b0, 1'b0, 1'b1, 1'b1);

        // Unknown select steers to branch one.
        cyc(32'h99, 1'b1, 1'bx, 1'b1, 1'b1);
        chk("sel_x_one", {63'd0, bus.ou_one_valid}, 64'd1);
        chk("sel_x_two", {63'd0, bus.ou_two_valid}, 64'd0);

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            cyc($urandom, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 2) != 0));
        end

`ifdef DEMUX_COUNT_EN
        // Counter wrap after 257 beats into branch one.
        apply_reset();
        for (int i = 0; i < 257; i++) cyc(W'(i), 1'b1, 1'b0, 1'b1, 1'b1);
        chk("b034_one_cnt", {56'd0, one_cnt}, 64'd1);
        chk("b034_two_cnt", {56'd0, two_cnt}, 64'd0);
`endif

        // Reset with both slots full clears them without a clock edge.
        cyc(32'h0, 1'b0, 1'b0, 1'b1, 1'b1);
        cyc(32'hC1, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(32'hC2, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("b035_full1", {63'd0, bus.ou_one_valid}, 64'd1);
        chk("b035_full2", {63'd0, bus.ou_two_valid}, 64'd1);
        #2;
        apply_reset();
        cyc(32'hD1, 1'b1, 1'b0, 1'b1, 1'b1);
        chk("post_rst", {32'd0, bus.ou_one_data}, 64'hD1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule : tb_demux_one_to_two
